spi_master_tx: RTL
==================

# spi_master_tx

SPI master transmitter that shifts a parallel word out MSB-first on sck/mosi, framed by an active-low chip select. It is the output-side counterpart of the PV input master: the PID controller's 4-bit stimulus goes to an external DAC or actuator over it, started by the delayed PID strobe. Mode 0 framing (sck idle low, data stable on rising edge) matches the input path, and cs rises at end of frame like the input master.

## Interface
- BITS, 4, word width shifted per frame (>=1)
- DIV, 1, sck half-period in clk cycles (>=1; 0 illegal)
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a frame; sampled every clk
- in_buf  input  BITS  word to transmit; captured on the cycle start is accepted
- sck  output  1  serial clock, idle low
- cs  output  1  chip select, active low, idle high
- mosi  output  1  serial data, MSB first, 0 when idle
- busy  output  1  high while a frame is in progress
- done  output  1  one-cycle pulse on the cycle cs returns high

## Operation
- Reset values: cs=1, sck=0, mosi=0, busy=0, done=0; shift register, bit counter, divider counter cleared; state IDLE.
- States: IDLE, LEAD, HIGH, LOW.
- IDLE: start=1 with busy=0 accepts the frame; in_buf latched into shift register; next cycle -> LEAD.
- LEAD: cs=0, sck=0, mosi=in_buf[BITS-1]; lasts DIV cycles -> HIGH.
- HIGH: sck=1, mosi held; lasts DIV cycles -> LOW.
- LOW: sck=0; on entry mosi advances to next lower bit (after the last bit mosi drives 0); lasts DIV cycles; if bits remain -> HIGH, else -> IDLE with cs=1, done=1 for that one cycle.
- busy=1 from the cycle after acceptance through the last LOW cycle; busy=0 on the done cycle.
- start while busy: ignored (unless SPI_MASTER_TX_QUEUE_EN).
- start on the done cycle: accepted; cs high for exactly one cycle between frames.
- in_buf changes after acceptance do not affect the frame in flight.
- reset mid-frame: next edge forces all reset values; no done pulse; frame abandoned.
- Divider counter width: $clog2(DIV+1); bit counter width: $clog2(BITS+1).

## Timing
- Start-to-cs-low latency: 1 clk.
- cs low duration: DIV*(1+2*BITS) clk; BITS=4, DIV=1 -> 9 clk.
- Bit i (MSB=first) valid from falling sck edge preceding its rising edge; stable DIV clk before and DIV clk after each sck rising edge.
- Number of sck rising edges per frame: exactly BITS.
- Minimum frame-to-frame period: DIV*(1+2*BITS)+1 clk.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- SPI_MASTER_TX_QUEUE_EN defined: single-entry holding register. start while busy and queue empty captures in_buf into the queue; a further start while queue full overwrites the queued word (latest value wins). On the done cycle a queued word is launched as if start were asserted: cs low again next cycle; queue cleared. Reset clears the queue.
- Not defined: no holding register; start while busy is dropped; behaviour exactly as in Operation.

## Test plan
- Single frame, BITS=4, DIV=1, in_buf=4'hA: start 1 clk -> cs low 9 clk, mosi at 4 sck rising edges = 1,0,1,0; done pulses once as cs rises; busy high 9 clk.
- DIV=3, in_buf=4'h5: cs low 27 clk; sck high/low 3 clk each; sampled bits 0,1,0,1; mosi never changes while sck=1.
- Back-to-back: hold start high continuously, in_buf=4'hF then 4'h0 -> frames separated by exactly 1 cycle cs high; sampled words F then 0.
- Start while busy (macro off): start at cycle 3 of frame with in_buf=4'h3 -> ignored; only the first word appears; one done pulse.
- Start while busy (SPI_MASTER_TX_QUEUE_EN): first word 4'hC, mid-frame starts with 4'h1 then 4'h6 -> second frame starts cycle after done and carries 4'h6.
- Reset at 5th cycle of a frame -> next cycle cs=1, sck=0, mosi=0, busy=0; no done; fresh start afterwards transmits correctly.

Source files
------------

// File: rtl/spi_master_tx_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module   : spi_master_tx_if
// | Brief    : Parallel request side and serial line side of the SPI master TX.
// | Revision : 1.0 - initial release
// +-----------------------------------------------------------------------------
interface spi_master_tx_if #(
    parameter int BITS = 4
);
    logic            start;
    logic [BITS-1:0] in_buf;
    logic            sck;
    logic            cs;
    logic            mosi;
    logic            busy;
    logic            done;

    modport master (
        input  start,
        input  in_buf,
        output sck,
        output cs,
        output mosi,
        output busy,
        output done
    );

    modport slave (
        output start,
        output in_buf,
        input  sck,
        input  cs,
        input  mosi,
        input  busy,
        input  done
    );
endinterface
`default_nettype wire

// File: rtl/spi_master_tx.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module   : spi_master_tx
// | Brief    : Mode-0 SPI master transmitter, MSB first, active-low cs.
// |            Optional one-word holding register: SPI_MASTER_TX_QUEUE_EN.
// | Revision : 1.0 - initial release
// +-----------------------------------------------------------------------------
module spi_master_tx #(
    parameter int BITS = 4,
    parameter int DIV  = 1
) (
    input  wire logic       clk,
    input  wire logic       reset,
    spi_master_tx_if.master bus
);
    localparam int DW = $clog2(DIV + 1);
    localparam int BW = $clog2(BITS + 1);
    localparam logic [DW-1:0] c_DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] c_BITS     = BW'(BITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LEAD = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [DW-1:0]   r_div_cnt, w_div_nxt;
    logic [BW-1:0]   r_bit_cnt, w_bit_nxt;
    logic [BITS-1:0] r_shreg, w_shreg_nxt;
    logic            w_done_nxt;
    logic            w_launch;
    logic [BITS-1:0] w_launch_data;
    logic            r_cs, r_sck, r_mosi, r_busy, r_done;

`ifdef SPI_MASTER_TX_QUEUE_EN
    logic            r_q_valid, w_q_valid_nxt;
    logic [BITS-1:0] r_q_data, w_q_data_nxt;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shreg_nxt = r_shreg;
        w_done_nxt  = 1'b0;
`ifdef SPI_MASTER_TX_QUEUE_EN
        // A queued word outranks a fresh start on the done cycle.
        w_launch      = r_q_valid | bus.start;
        w_launch_data = r_q_valid ? r_q_data : bus.in_buf;
        w_q_valid_nxt = r_q_valid;
        w_q_data_nxt  = r_q_data;
        if (r_state != IDLE && bus.start) begin
            w_q_valid_nxt = 1'b1;
            w_q_data_nxt  = bus.in_buf;
        end else if (r_state == IDLE) begin
            w_q_valid_nxt = 1'b0;
        end
`else
        w_launch      = bus.start;
        w_launch_data = bus.in_buf;
`endif
        case (r_state)
            IDLE: begin
                if (w_launch) begin
                    w_state_nxt = LEAD;
                    w_div_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_shreg_nxt = w_launch_data;
                end
            end
            LEAD: begin
                if (r_div_cnt == c_DIV_LAST) begin
                    w_state_nxt = HIGH;
                    w_div_nxt   = '0;
                end else begin
                    w_div_nxt = r_div_cnt + 1'b1;
                end
            end
            HIGH: begin
                // Shifting on the way into LOW advances mosi on the falling edge.
                if (r_div_cnt == c_DIV_LAST) begin
                    w_state_nxt = LOW;
                    w_div_nxt   = '0;
                    w_bit_nxt   = r_bit_cnt + 1'b1;
                    w_shreg_nxt = r_shreg << 1;
                end else begin
                    w_div_nxt = r_div_cnt + 1'b1;
                end
            end
            LOW: begin
                if (r_div_cnt == c_DIV_LAST) begin
                    w_div_nxt = '0;
                    if (r_bit_cnt == c_BITS) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = HIGH;
                    end
                end else begin
                    w_div_nxt = r_div_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
            r_cs      <= 1'b1;
            r_sck     <= 1'b0;
            r_mosi    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_div_cnt <= w_div_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_shreg   <= w_shreg_nxt;
            r_cs      <= (w_state_nxt == IDLE);
            r_sck     <= (w_state_nxt == HIGH);
            r_mosi    <= (w_state_nxt != IDLE) & w_shreg_nxt[BITS-1];
            r_busy    <= (w_state_nxt != IDLE);
            r_done    <= w_done_nxt;
        end
    end

`ifdef SPI_MASTER_TX_QUEUE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q_valid <= 1'b0;
            r_q_data  <= '0;
        end else begin
            r_q_valid <= w_q_valid_nxt;
            r_q_data  <= w_q_data_nxt;
        end
    end
`endif

    assign bus.cs   = r_cs;
    assign bus.sck  = r_sck;
    assign bus.mosi = r_mosi;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
endmodule
`default_nettype wire
